// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and timing sequencer for an async 16-bit SRAM
module sram_arbiter #(
  parameter int WaitCycles = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        P0_Req,
  input  logic        P0_WE,
  input  logic [1:0]  P0_BE,
  input  logic [19:0] P0_Addr,
  input  logic [15:0] P0_WData,
  output logic        P0_Ack,
  output logic [15:0] P0_RData,
  input  logic        P1_Req,
  input  logic        P1_WE,
  input  logic [1:0]  P1_BE,
  input  logic [19:0] P1_Addr,
  input  logic [15:0] P1_WData,
  output logic        P1_Ack,
  output logic [15:0] P1_RData,
  output logic        Busy,
  output logic        SRAM_CE,
  output logic        SRAM_OE,
  output logic        SRAM_WE,
  output logic        SRAM_LB,
  output logic        SRAM_UB,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic port, last_grant, wr, dq_en, req, gnt, g_wr;
  logic [1:0] be, g_be, nxt_ack;
  logic [15:0] wdata;
  logic nxt_ce, nxt_oe, nxt_we, nxt_lb, nxt_ub, nxt_dq;
  // port 1 wins when it is alone or when port 0 was served last
  assign req = P0_Req || P1_Req;
  assign gnt = P1_Req && (!P0_Req || !last_grant);
  assign g_wr = gnt ? P1_WE : P0_WE;
  assign g_be = gnt ? P1_BE : P0_BE;
  assign Busy = state != IDLE;
  assign SRAM_DQ = dq_en ? wdata : {16{1'bz}};
  // next state and next values of the registered SRAM controls and acks
  always_comb begin
    state_n = state;
    nxt_ce = 1'b1;
    nxt_oe = 1'b1;
    nxt_we = 1'b1;
    nxt_lb = 1'b1;
    nxt_ub = 1'b1;
    nxt_dq = 1'b0;
    nxt_ack = 2'b00;
    case (state)
      IDLE: if (req) begin
        state_n = ACCESS;
        nxt_ce = 1'b0;
        nxt_oe = g_wr;
        nxt_we = !g_wr;
        nxt_ub = !g_be[1];
        nxt_lb = !g_be[0];
        nxt_dq = g_wr;
      end
      ACCESS: if (cnt == 4'd0) begin
        state_n = DONE;
        nxt_dq = wr;
        nxt_ack = port ? 2'b10 : 2'b01;
      end else begin
        nxt_ce = 1'b0;
        nxt_oe = wr;
        nxt_we = !wr;
        nxt_ub = !be[1];
        nxt_lb = !be[0];
        nxt_dq = wr;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register and registered SRAM controls, DQ enable and acks
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB} <= 5'h1f;
      dq_en <= 1'b0;
      {P1_Ack, P0_Ack} <= 2'b00;
    end else begin
      state <= state_n;
      {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB} <= {nxt_ce, nxt_oe, nxt_we, nxt_lb, nxt_ub};
      dq_en <= nxt_dq;
      {P1_Ack, P0_Ack} <= nxt_ack;
    end
  end
  // transaction latch at grant, wait-state counter and read data capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      port <= 1'b0;
      last_grant <= 1'b1;
      cnt <= 4'd0;
      wr <= 1'b0;
      be <= 2'b00;
      wdata <= 16'h0000;
      SRAM_ADDR <= 20'h00000;
      P0_RData <= 16'h0000;
      P1_RData <= 16'h0000;
    end else begin
      if (state == IDLE && req) begin
        port <= gnt;
        last_grant <= gnt;
        cnt <= 4'(WaitCycles);
        wr <= g_wr;
        be <= g_be;
        wdata <= gnt ? P1_WData : P0_WData;
        SRAM_ADDR <= gnt ? P1_Addr : P0_Addr;
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == ACCESS && cnt == 4'd0 && !wr && !port) P0_RData <= SRAM_DQ;
      if (state == ACCESS && cnt == 4'd0 && !wr && port) P1_RData <= SRAM_DQ;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of arbitration, SRAM waveform and latency with SRAM models
module tb_sram_arbiter;
  logic Clk = 0, Reset = 1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, b_req = 0;
  logic [1:0] p0_be = 0, p1_be = 0;
  logic [19:0] p0_addr = 0, p1_addr = 0;
  logic [15:0] p0_wd = 0, p1_wd = 0;
  logic a_ack0, a_ack1, a_busy, a_ce, a_oe, a_we, a_lb, a_ub;
  logic b_ack0, b_ack1, b_busy, b_ce, b_oe, b_we, b_lb, b_ub;
  logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic [19:0] a_addr, b_addr;
  tri1 [15:0] a_dq, b_dq;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  int errors = 0, checks = 0;
  logic use_b = 0;
  always #5 Clk = ~Clk;
  sram_arbiter #(.WaitCycles(1)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .P0_Req(p0_req), .P0_WE(p0_we), .P0_BE(p0_be), .P0_Addr(p0_addr), .P0_WData(p0_wd),
    .P0_Ack(a_ack0), .P0_RData(a_rd0),
    .P1_Req(p1_req), .P1_WE(p1_we), .P1_BE(p1_be), .P1_Addr(p1_addr), .P1_WData(p1_wd),
    .P1_Ack(a_ack1), .P1_RData(a_rd1),
    .Busy(a_busy), .SRAM_CE(a_ce), .SRAM_OE(a_oe), .SRAM_WE(a_we), .SRAM_LB(a_lb), .SRAM_UB(a_ub),
    .SRAM_ADDR(a_addr), .SRAM_DQ(a_dq));
  sram_arbiter #(.WaitCycles(0)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .P0_Req(b_req), .P0_WE(p0_we), .P0_BE(p0_be), .P0_Addr(p0_addr), .P0_WData(p0_wd),
    .P0_Ack(b_ack0), .P0_RData(b_rd0),
    .P1_Req(1'b0), .P1_WE(1'b0), .P1_BE(2'b00), .P1_Addr(20'h0), .P1_WData(16'h0),
    .P1_Ack(b_ack1), .P1_RData(b_rd1),
    .Busy(b_busy), .SRAM_CE(b_ce), .SRAM_OE(b_oe), .SRAM_WE(b_we), .SRAM_LB(b_lb), .SRAM_UB(b_ub),
    .SRAM_ADDR(b_addr), .SRAM_DQ(b_dq));
  // behavioural SRAMs: drive DQ on read, latch byte lanes while CE and WE are low
  assign a_dq = (!a_ce && !a_oe) ? mem_a[a_addr[7:0]] : {16{1'bz}};
  assign b_dq = (!b_ce && !b_oe) ? mem_b[b_addr[7:0]] : {16{1'bz}};
  always @(posedge Clk) begin
    if (!a_ce && !a_we && !a_lb) mem_a[a_addr[7:0]][7:0] <= a_dq[7:0];
    if (!a_ce && !a_we && !a_ub) mem_a[a_addr[7:0]][15:8] <= a_dq[15:8];
    if (!b_ce && !b_we && !b_lb) mem_b[b_addr[7:0]][7:0] <= b_dq[7:0];
    if (!b_ce && !b_we && !b_ub) mem_b[b_addr[7:0]][15:8] <= b_dq[15:8];
  end
  wire o_we = use_b ? b_we : a_we;
  wire o_oe = use_b ? b_oe : a_oe;
  wire o_lb = use_b ? b_lb : a_lb;
  wire o_ub = use_b ? b_ub : a_ub;
  wire o_ack0 = use_b ? b_ack0 : a_ack0;
  wire o_ack1 = use_b ? b_ack1 : a_ack1;
  wire [15:0] o_dq = use_b ? b_dq : a_dq;
  wire [15:0] o_rd0 = use_b ? b_rd0 : a_rd0;
  wire [15:0] o_rd1 = use_b ? b_rd1 : a_rd1;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one transaction; lat counts edges from the grant edge to the first Ack cycle (0 = timed out)
  task automatic xfer(input logic sel, input logic port, input logic wr, input logic [1:0] be,
                      input logic [19:0] addr, input logic [15:0] wd, output int lat, output int we_lo,
                      output int oe_lo, output int dq_hold, output logic lb, output logic ub,
                      output logic [15:0] rd);
    lat = 0; we_lo = 0; oe_lo = 0; dq_hold = 0; lb = 1; ub = 1; rd = 0;
    use_b = sel;
    if (port) begin p1_we = wr; p1_be = be; p1_addr = addr; p1_wd = wd; end
    else begin p0_we = wr; p0_be = be; p0_addr = addr; p0_wd = wd; end
    if (sel) b_req = 1; else if (port) p1_req = 1; else p0_req = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin lb = o_lb; ub = o_ub; end
      we_lo += int'(!o_we);
      oe_lo += int'(!o_oe);
      dq_hold += int'(o_dq === wd);
      if (port ? o_ack1 : o_ack0) begin
        lat = k;
        rd = port ? o_rd1 : o_rd0;
        break;
      end
    end
    b_req = 0; p0_req = 0; p1_req = 0;
    tick();
  endtask
  int lat, we_lo, oe_lo, dqh, n, both;
  logic lb, ub;
  logic [15:0] rd;
  logic order [4];
  initial begin
    for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h0000; mem_b[i] = 16'h0000; end
    mem_b[8'h40] = 16'h5A5A;
    tick(); tick();
    chk("rst_ctl", {27'd0, a_ce, a_oe, a_we, a_lb, a_ub}, 32'h1f);
    chk("rst_dq", a_dq, 16'hffff);
    chk("rst_ack_busy", {a_ack0, a_ack1, a_busy}, 0);
    chk("rst_rdata", {a_rd0, a_rd1}, 0);
    chk("rst_addr", a_addr, 0);
    Reset = 0;
    tick();
    chk("idle_busy", a_busy, 0);
    xfer(0, 0, 1, 2'b11, 20'h00010, 16'hBEEF, lat, we_lo, oe_lo, dqh, lb, ub, rd);
    chk("w0_lat", lat, 3);
    chk("w0_we_low", we_lo, 2);
    chk("w0_oe_low", oe_lo, 0);
    chk("w0_dq_hold", dqh, 3);
    chk("w0_bytes", {lb, ub}, 2'b00);
    chk("w0_dq_release", a_dq, 16'hffff);
    xfer(0, 0, 0, 2'b11, 20'h00010, 16'h0000, lat, we_lo, oe_lo, dqh, lb, ub, rd);
    chk("r0_lat", lat, 3);
    chk("r0_oe_low", oe_lo, 2);
    chk("r0_we_low", we_lo, 0);
    chk("r0_rdata", rd, 16'hBEEF);
    xfer(0, 1, 1, 2'b01, 20'h00010, 16'h12AB, lat, we_lo, oe_lo, dqh, lb, ub, rd);
    chk("w1_lat", lat, 3);
    chk("w1_lb_ub", {lb, ub}, 2'b01);
    xfer(0, 1, 0, 2'b11, 20'h00010, 16'h0000, lat, we_lo, oe_lo, dqh, lb, ub, rd);
    chk("r1_rdata", rd, 16'hBEAB);
    chk("r0_rdata_held", a_rd0, 16'hBEEF);
    Reset = 1; tick(); tick(); Reset = 0;
    p0_we = 0; p1_we = 0; p0_be = 2'b11; p1_be = 2'b11; p0_addr = 20'h10; p1_addr = 20'h10;
    p0_req = 1; p1_req = 1; n = 0; both = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      both += int'(a_ack0 && a_ack1);
      if (a_ack0 || a_ack1) begin order[n] = a_ack1; n++; end
    end
    p0_req = 0; p1_req = 0;
    chk("rr_count", n, 4);
    chk("rr_order", {28'd0, order[0], order[1], order[2], order[3]}, 4'b0101);
    chk("rr_both_ack", both, 0);
    Reset = 1; tick(); tick(); Reset = 0;
    p1_we = 1; p1_be = 2'b11; p1_addr = 20'h00020; p1_wd = 16'h7777; p1_req = 1;
    tick(); tick();
    chk("abort_pre", {a_busy, a_ce, a_we}, 3'b100);
    Reset = 1; p1_req = 0;
    tick();
    chk("abort_ctl", {a_ce, a_we, a_busy, a_ack1}, 4'b1100);
    chk("abort_dq", a_dq, 16'hffff);
    Reset = 0;
    tick();
    chk("abort_no_ack", {a_ack1, a_busy}, 2'b00);
    xfer(1, 0, 0, 2'b11, 20'h00040, 16'h0000, lat, we_lo, oe_lo, dqh, lb, ub, rd);
    chk("w0inst_lat", lat, 2);
    chk("w0inst_oe_low", oe_lo, 1);
    chk("w0inst_rdata", rd, 16'h5A5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
